// File: rtl/matrix_multiplier_pkg.sv
// Shared types and widths for the streaming matrix multiplier.
package matrix_multiplier_pkg;

  localparam int DATA_W      = 8;
  localparam int OUT_W       = 20;
  localparam int PROD_W      = 2 * DATA_W;
  localparam int DEF_MAX_DIM = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_CALC
  } state_t;

  function automatic logic signed [OUT_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return OUT_W'(p);
  endfunction

endpackage

// File: rtl/matrix_multiplier_dot.sv
// Combinational signed dot product of up to MAX_DIM terms; terms at or beyond len contribute zero.
module matrix_multiplier_dot
  import matrix_multiplier_pkg::*;
#(
  parameter int MAX_DIM = DEF_MAX_DIM,
  parameter int LEN_W   = $clog2(MAX_DIM + 1)
) (
  input  logic [MAX_DIM*DATA_W-1:0] a_vec,
  input  logic [MAX_DIM*DATA_W-1:0] b_vec,
  input  logic [LEN_W-1:0]          len,
  output logic signed [OUT_W-1:0]   sum
);

  logic signed [PROD_W-1:0] prod [MAX_DIM];

  always_comb begin
    for (int k = 0; k < MAX_DIM; k++) begin
      prod[k] = '0;
      if (k < int'(len)) begin
        prod[k] = PROD_W'(signed'(a_vec[k*DATA_W +: DATA_W])) *
                  PROD_W'(signed'(b_vec[k*DATA_W +: DATA_W]));
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < MAX_DIM; k++) begin
      sum = sum + sext_prod(prod[k]);
    end
  end

endmodule

// File: rtl/matrix_multiplier.sv
// Streaming matrix multiplier: loads A then B row-major, emits C = A*B one element every other cycle.
module matrix_multiplier
  import matrix_multiplier_pkg::*;
#(
  parameter int MAX_DIM = DEF_MAX_DIM
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     col_end,
  input  logic                     row_end,
  output logic                     busy,
  output logic                     valid,
  output logic                     is_legal,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     change_row
);

  localparam int IDX_W  = $clog2(MAX_DIM + 1);
  localparam int DEPTH  = MAX_DIM * MAX_DIM;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t                   state;
  logic [IDX_W-1:0]         row, col;
  logic [IDX_W-1:0]         rows_a, cols_a, rows_b, cols_b;
  logic [IDX_W-1:0]         i_idx, j_idx;
  logic                     phase, done;
  logic signed [DATA_W-1:0] a_mem [DEPTH];
  logic signed [DATA_W-1:0] b_mem [DEPTH];
  logic [ADDR_W-1:0]        wr_addr;
  logic [MAX_DIM*DATA_W-1:0] a_vec, b_vec;
  logic signed [OUT_W-1:0]  dot_sum;
  logic                     legal, last_col;

  assign wr_addr  = ADDR_W'(int'(row) * MAX_DIM + int'(col));
  assign legal    = (cols_a == rows_b);
  assign last_col = (j_idx == cols_b - IDX_W'(1));

  // Operand storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD_A) a_mem[wr_addr] <= in_data;
    if (state == ST_LOAD_B) b_mem[wr_addr] <= in_data;
  end

  always_comb begin
    a_vec = '0;
    b_vec = '0;
    for (int k = 0; k < MAX_DIM; k++) begin
      a_vec[k*DATA_W +: DATA_W] = a_mem[ADDR_W'(int'(i_idx) * MAX_DIM + k)];
      b_vec[k*DATA_W +: DATA_W] = b_mem[ADDR_W'(k * MAX_DIM + int'(j_idx))];
    end
  end

  matrix_multiplier_dot #(
    .MAX_DIM (MAX_DIM),
    .LEN_W   (IDX_W)
  ) u_dot (
    .a_vec (a_vec),
    .b_vec (b_vec),
    .len   (cols_a),
    .sum   (dot_sum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b1;
      valid      <= 1'b0;
      is_legal   <= 1'b0;
      change_row <= 1'b0;
      out_data   <= '0;
      row        <= '0;
      col        <= '0;
      rows_a     <= '0;
      cols_a     <= '0;
      rows_b     <= '0;
      cols_b     <= '0;
      i_idx      <= '0;
      j_idx      <= '0;
      phase      <= 1'b0;
      done       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          state <= ST_LOAD_A;
          busy  <= 1'b0;
          row   <= '0;
          col   <= '0;
        end
        ST_LOAD_A, ST_LOAD_B: begin
          if (col_end) begin
            col <= '0;
            row <= row + IDX_W'(1);
            // The first completed row fixes the column count.
            if (row == '0) begin
              if (state == ST_LOAD_A) cols_a <= col + IDX_W'(1);
              else                    cols_b <= col + IDX_W'(1);
            end
          end else begin
            col <= col + IDX_W'(1);
          end
          if (row_end) begin
            row <= '0;
            col <= '0;
            if (state == ST_LOAD_A) begin
              rows_a <= row + IDX_W'(1);
              state  <= ST_LOAD_B;
            end else begin
              rows_b <= row + IDX_W'(1);
              state  <= ST_CALC;
              busy   <= 1'b1;
              phase  <= 1'b0;
              done   <= 1'b0;
              i_idx  <= '0;
              j_idx  <= '0;
            end
          end
        end
        ST_CALC: begin
          // Phase 0 is the settle cycle, phase 1 registers a result.
          if (!phase) begin
            phase <= 1'b1;
            if (done) state <= ST_IDLE;
          end else begin
            phase <= 1'b0;
            valid <= 1'b1;
            if (legal) begin
              out_data   <= dot_sum;
              is_legal   <= 1'b1;
              change_row <= last_col;
              if (last_col) begin
                j_idx <= '0;
                if (i_idx == rows_a - IDX_W'(1)) done  <= 1'b1;
                else                             i_idx <= i_idx + IDX_W'(1);
              end else begin
                j_idx <= j_idx + IDX_W'(1);
              end
            end else begin
              out_data   <= '0;
              is_legal   <= 1'b0;
              change_row <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_multiplier.sv
// Randomized and directed checks of matrix_multiplier against a plain-arithmetic matrix product model.
module tb_matrix_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = '0;
  logic        col_end = 1'b0;
  logic        row_end = 1'b0;
  logic        busy, valid, is_legal, change_row;
  logic [19:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;
  int a_m [16];
  int b_m [16];

  matrix_multiplier #(.MAX_DIM(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .col_end    (col_end),
    .row_end    (row_end),
    .busy       (busy),
    .valid      (valid),
    .is_legal   (is_legal),
    .out_data   (out_data),
    .change_row (change_row)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy !== 1'b0) chk("ready_timeout", 32'(busy), 32'd0);
  endtask

  task automatic drive(input int m, input int n, input int p, input int q, input int b_lim);
    for (int idx = 0; idx < m * n; idx++) begin
      chk("busy_load_a", 32'(busy), 32'd0);
      in_data = 8'(a_m[idx]);
      col_end = ((idx % n) == n - 1);
      row_end = (idx == m * n - 1);
      @(negedge clk);
    end
    for (int idx = 0; idx < p * q && idx < b_lim; idx++) begin
      chk("busy_load_b", 32'(busy), 32'd0);
      in_data = 8'(b_m[idx]);
      col_end = ((idx % q) == q - 1);
      row_end = (idx == p * q - 1);
      @(negedge clk);
    end
  endtask

  task automatic run_case(input int m, input int n, input int p, input int q);
    logic [19:0] exp_d [$];
    logic        exp_cr [$];
    logic        leg;
    int          nout, s, k;
    logic        pulse;
    leg = (n == p);
    if (leg) begin
      for (int i = 0; i < m; i++)
        for (int j = 0; j < q; j++) begin
          s = 0;
          for (int kk = 0; kk < n; kk++) s += a_m[i*n+kk] * b_m[kk*q+j];
          exp_d.push_back(20'(s));
          exp_cr.push_back(j == q - 1);
        end
    end else begin
      exp_d.push_back(20'd0);
      exp_cr.push_back(1'b0);
    end
    nout = exp_d.size();
    wait_ready();
    drive(m, n, p, q, p * q);
    for (int c = 0; c <= 2 * nout + 2; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) begin
        in_data = '0;
        col_end = 1'b0;
        row_end = 1'b0;
      end
      pulse = (c >= 2) && (c % 2 == 0) && (c <= 2 * nout);
      chk("valid", 32'(valid), 32'(pulse));
      chk("busy_calc", 32'(busy), 32'(c <= 2 * nout + 1));
      if (pulse) begin
        k = (c - 2) / 2;
        chk("out_data", 32'(out_data), 32'(exp_d[k]));
        chk("is_legal", 32'(is_legal), 32'(leg));
        chk("change_row", 32'(change_row), 32'(exp_cr[k]));
      end else if (c >= 3) begin
        chk("hold", 32'(out_data), 32'(exp_d[(c-3)/2]));
      end
    end
  endtask

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  initial begin
    int m, n, p, q;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_is_legal", 32'(is_legal), 32'd0);
    chk("rst_change_row", 32'(change_row), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b1;

    a_m[0] = 1; a_m[1] = 2; a_m[2] = 3; a_m[3] = 4;
    b_m[0] = 5; b_m[1] = 6; b_m[2] = 7; b_m[3] = 8;
    run_case(2, 2, 2, 2);

    a_m[0] = -1; a_m[1] = -2; a_m[2] = -3;
    b_m[0] = 4;  b_m[1] = 5;  b_m[2] = 6;
    run_case(1, 3, 3, 1);

    for (int idx = 0; idx < 6; idx++) a_m[idx] = idx + 1;
    for (int idx = 0; idx < 4; idx++) b_m[idx] = idx - 2;
    run_case(2, 3, 2, 2);

    for (int idx = 0; idx < 16; idx++) begin
      a_m[idx] = -128;
      b_m[idx] = -128;
    end
    run_case(4, 4, 4, 4);
    a_m[0] = 3;
    b_m[0] = -2;
    run_case(1, 1, 1, 1);

    // Abort mid-B, then confirm a clean stream still computes correctly.
    a_m[0] = 9; a_m[1] = -7; a_m[2] = 11; a_m[3] = 2;
    b_m[0] = 3; b_m[1] = 4;  b_m[2] = -5; b_m[3] = 6;
    wait_ready();
    drive(2, 2, 2, 2, 2);
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    in_data = '0;
    col_end = 1'b0;
    row_end = 1'b0;
    rst = 1'b1;
    run_case(2, 2, 2, 2);

    repeat (10) begin
      m = int'($urandom_range(1, 4));
      n = int'($urandom_range(1, 4));
      q = int'($urandom_range(1, 4));
      p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : n;
      for (int idx = 0; idx < 16; idx++) begin
        a_m[idx] = rnd8();
        b_m[idx] = rnd8();
      end
      run_case(m, n, p, q);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
